// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS2 gamepad responder.
// Holds register offsets, FSM encoding and the protocol bytes.
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_ACK_WAIT,
        ST_ACK_PULSE,
        ST_IGNORE
    } state_e;

    localparam logic [1:0] REG_BUTTONS = 2'd0;
    localparam logic [1:0] REG_STATUS  = 2'd1;
    localparam logic [1:0] REG_CTRL    = 2'd2;

    localparam logic [7:0] CMD_START = 8'h01;
    localparam logic [7:0] CMD_POLL  = 8'h42;
    localparam logic [7:0] RSP_IDLE  = 8'hFF;
    localparam logic [7:0] RSP_ID    = 8'h41;
    localparam logic [7:0] RSP_READY = 8'h5A;

    localparam logic [15:0] BUTTONS_RST = 16'hFFFF;

    function automatic logic [7:0] resp_byte(
        input logic [2:0]  idx,
        input logic [15:0] snap
    );
        logic [7:0] b;
        case (idx)
            3'd0:    b = RSP_IDLE;
            3'd1:    b = RSP_ID;
            3'd2:    b = RSP_READY;
            3'd3:    b = snap[7:0];
            3'd4:    b = snap[15:8];
            default: b = RSP_IDLE;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/ps2_pad_responder_if.sv
// APB3 register bus bundle for the PS2 pad responder.
interface ps2_pad_responder_if;

    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );

endinterface

// File: rtl/ps2_sync_edge.sv
// Two-flop synchroniser with edge detect on the synchronised value.
// Edges stay masked until both stages and the history flop hold real samples.
module ps2_sync_edge
    import ps2_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic level,
    output logic fall,
    output logic rise
);

    logic       s1_q, s1_d;
    logic       s2_q, s2_d;
    logic       prev_q, prev_d;
    logic [1:0] warm_q, warm_d;
    logic       live;

    always_comb begin
        s1_d   = d;
        s2_d   = s1_q;
        prev_d = s2_q;
        warm_d = (warm_q == 2'd3) ? warm_q : warm_q + 2'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q   <= 1'b1;
            s2_q   <= 1'b1;
            prev_q <= 1'b1;
            warm_q <= 2'd0;
        end else begin
            s1_q   <= s1_d;
            s2_q   <= s2_d;
            prev_q <= prev_d;
            warm_q <= warm_d;
        end
    end

    // A level held low across reset release must not look like a fall.
    assign live  = (warm_q == 2'd3);
    assign level = s2_q;
    assign fall  = live & prev_q & ~s2_q;
    assign rise  = live & ~prev_q & s2_q;

endmodule

// File: rtl/ps2_pad_responder.sv
// PS2 gamepad responder: APB button/ctrl registers and host-side
// serial FSM answering the 0x01/0x42 poll with a five-byte reply.
module ps2_pad_responder
    import ps2_pkg::*;
#(
    parameter int ACK_DELAY = 200,
    parameter int ACK_WIDTH = 100
) (
    input  logic PCLK,
    input  logic PRESERN,
    ps2_pad_responder_if.slave apb,
    input  logic ATTENTION,
    input  logic PS2_CLOCK,
    input  logic COMMAND,
    output logic DATA,
    output logic ACK
);

    localparam logic [15:0] DLY_LAST = 16'(ACK_DELAY - 1);
    localparam logic [15:0] WID_LAST = 16'(ACK_WIDTH - 1);

    state_e      state_q, state_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [2:0]  byte_cnt_q, byte_cnt_d;
    logic [7:0]  tx_q, tx_d;
    logic [7:0]  rx_q, rx_d;
    logic [15:0] snap_q, snap_d;
    logic        data_q, data_d;
    logic        ack_q, ack_d;
    logic [15:0] timer_q, timer_d;
    logic        busy_q, busy_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic [15:0] buttons_q, buttons_d;
    logic        enable_q, enable_d;
    logic [31:0] prdata_q, prdata_d;

    logic att_lvl_unused, att_fall, att_rise;
    logic ps2_lvl_unused, ps2_fall, ps2_rise;
    logic cmd_lvl, cmd_fall_unused, cmd_rise_unused;
    logic apb_unused;

    logic [1:0] reg_sel;
    logic       apb_wr;
    logic       apb_rd;
    logic [7:0] rx_byte;
    logic       byte_bad;

    ps2_sync_edge u_att (
        .clk   (PCLK),
        .rst_n (PRESERN),
        .d     (ATTENTION),
        .level (att_lvl_unused),
        .fall  (att_fall),
        .rise  (att_rise)
    );

    ps2_sync_edge u_clk (
        .clk   (PCLK),
        .rst_n (PRESERN),
        .d     (PS2_CLOCK),
        .level (ps2_lvl_unused),
        .fall  (ps2_fall),
        .rise  (ps2_rise)
    );

    ps2_sync_edge u_cmd (
        .clk   (PCLK),
        .rst_n (PRESERN),
        .d     (COMMAND),
        .level (cmd_lvl),
        .fall  (cmd_fall_unused),
        .rise  (cmd_rise_unused)
    );

    assign apb_unused = ^{apb.PADDR[31:4], apb.PADDR[1:0],
                          apb.PWDATA[31:16]};

    assign reg_sel  = apb.PADDR[3:2];
    assign apb_wr   = apb.PSEL & apb.PENABLE & apb.PWRITE;
    assign apb_rd   = apb.PSEL & ~apb.PWRITE;
    assign rx_byte  = {cmd_lvl, rx_q[7:1]};
    assign byte_bad = ((byte_cnt_q == 3'd0) && (rx_byte != CMD_START)) ||
                      ((byte_cnt_q == 3'd1) && (rx_byte != CMD_POLL));

    always_comb begin
        buttons_d = buttons_q;
        enable_d  = enable_q;
        prdata_d  = prdata_q;

        if (apb_wr) begin
            unique case (1'b1)
                reg_sel == REG_BUTTONS: buttons_d = apb.PWDATA[15:0];
                reg_sel == REG_CTRL:    enable_d  = apb.PWDATA[0];
                default: ;
            endcase
        end

        if (apb_rd) begin
            unique case (1'b1)
                reg_sel == REG_BUTTONS: prdata_d = {16'h0, buttons_q};
                reg_sel == REG_STATUS:  prdata_d = {15'h0, busy_q,
                                                    frame_cnt_q};
                reg_sel == REG_CTRL:    prdata_d = {31'h0, enable_q};
                default:                prdata_d = 32'h0;
            endcase
        end
    end

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        byte_cnt_d  = byte_cnt_q;
        tx_d        = tx_q;
        rx_d        = rx_q;
        snap_d      = snap_q;
        data_d      = data_q;
        ack_d       = ack_q;
        timer_d     = timer_q;
        frame_cnt_d = frame_cnt_q;

        // Host releasing ATTENTION ends the frame from any state.
        if (att_rise) begin
            state_d = ST_IDLE;
            data_d  = 1'b1;
            ack_d   = 1'b1;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (att_fall) begin
                        if (enable_q) begin
                            snap_d     = buttons_q;
                            tx_d       = RSP_IDLE;
                            rx_d       = 8'h00;
                            bit_cnt_d  = 3'd0;
                            byte_cnt_d = 3'd0;
                            state_d    = ST_SHIFT;
                        end else begin
                            state_d = ST_IGNORE;
                        end
                    end
                end
                ST_SHIFT: begin
                    if (ps2_fall) begin
                        data_d = tx_q[0];
                        tx_d   = {1'b1, tx_q[7:1]};
                    end else if (ps2_rise) begin
                        rx_d      = rx_byte;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            data_d = 1'b1;
                            if (byte_bad) begin
                                state_d = ST_IGNORE;
                            end else if (byte_cnt_q < 3'd4) begin
                                timer_d = 16'd0;
                                state_d = ST_ACK_WAIT;
                            end else begin
                                frame_cnt_d = frame_cnt_q + 16'd1;
                                state_d     = ST_IGNORE;
                            end
                        end
                    end
                end
                ST_ACK_WAIT: begin
                    timer_d = timer_q + 16'd1;
                    if (timer_q == DLY_LAST) begin
                        timer_d = 16'd0;
                        ack_d   = 1'b0;
                        state_d = ST_ACK_PULSE;
                    end
                end
                ST_ACK_PULSE: begin
                    timer_d = timer_q + 16'd1;
                    if (timer_q == WID_LAST) begin
                        ack_d      = 1'b1;
                        byte_cnt_d = byte_cnt_q + 3'd1;
                        tx_d       = resp_byte(byte_cnt_q + 3'd1, snap_q);
                        bit_cnt_d  = 3'd0;
                        state_d    = ST_SHIFT;
                    end
                end
                ST_IGNORE: begin
                    data_d = 1'b1;
                    ack_d  = 1'b1;
                end
                default: state_d = ST_IDLE;
            endcase
        end

        busy_d = (state_d == ST_SHIFT) || (state_d == ST_ACK_WAIT) ||
                 (state_d == ST_ACK_PULSE);
    end

    always_ff @(posedge PCLK or negedge PRESERN) begin
        if (!PRESERN) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= 3'd0;
            byte_cnt_q  <= 3'd0;
            tx_q        <= RSP_IDLE;
            rx_q        <= 8'h00;
            snap_q      <= BUTTONS_RST;
            data_q      <= 1'b1;
            ack_q       <= 1'b1;
            timer_q     <= 16'd0;
            busy_q      <= 1'b0;
            frame_cnt_q <= 16'd0;
            buttons_q   <= BUTTONS_RST;
            enable_q    <= 1'b0;
            prdata_q    <= 32'h0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            byte_cnt_q  <= byte_cnt_d;
            tx_q        <= tx_d;
            rx_q        <= rx_d;
            snap_q      <= snap_d;
            data_q      <= data_d;
            ack_q       <= ack_d;
            timer_q     <= timer_d;
            busy_q      <= busy_d;
            frame_cnt_q <= frame_cnt_d;
            buttons_q   <= buttons_d;
            enable_q    <= enable_d;
            prdata_q    <= prdata_d;
        end
    end

    assign DATA        = data_q;
    assign ACK         = ack_q;
    assign apb.PRDATA  = prdata_q;
    assign apb.PREADY  = 1'b1;
    assign apb.PSLVERR = 1'b0;

endmodule

// File: doc/ps2_pad_responder.md
PS2_PAD_RESPONDER -- requirements
Module: ps2_pad_responder

Interface
REQ-001 SHALL have parameter ACK_DELAY, default 200: PCLK cycles from the 8th sampled bit of a byte to ACK assertion.
REQ-002 SHALL have parameter ACK_WIDTH, default 100: PCLK cycles ACK is held low.
REQ-003 SHALL have port PCLK, input, 1: sole clock, all logic on rising edge.
REQ-004 SHALL have port PRESERN, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have APB3 slave ports: PSEL, PENABLE and PWRITE (input, 1 each); PADDR and PWDATA (input, 32 each); PRDATA (output, 32); PREADY and PSLVERR (output, 1 each).
REQ-006 SHALL have port ATTENTION, input, 1: asynchronous frame select from the host, active-low.
REQ-007 SHALL have port PS2_CLOCK, input, 1: asynchronous host bit clock, idle high.
REQ-008 SHALL have port COMMAND, input, 1: asynchronous host-to-pad serial data, LSB first.
REQ-009 SHALL have port DATA, output, 1: pad-to-host serial data, LSB first, idle high.
REQ-010 SHALL have port ACK, output, 1: per-byte acknowledge, active-low, idle high.

Function
REQ-011 SHALL tie PREADY to 1 and PSLVERR to 0; APB writes complete when PSEL&PENABLE&PWRITE; reads register PRDATA when PSEL&!PWRITE.
REQ-012 SHALL decode PADDR[3:2]: 0=BUTTONS (RW, [15:0], active-low button bits, reset 0xFFFF); 1=STATUS (RO: [15:0] frame_count, [16] busy); 2=CTRL (RW, [0] enable, reset 0); 3 reads 0, writes ignored.
REQ-013 SHALL pass ATTENTION, PS2_CLOCK and COMMAND through 2-flop synchronisers; edges are detected on synchronised values (3-cycle detection latency).
REQ-014 SHALL implement states IDLE, SHIFT, ACK_WAIT, ACK_PULSE, IGNORE.
REQ-015 IDLE: on synchronised ATTENTION falling edge with enable=1, SHALL snapshot BUTTONS, load TX byte 0xFF, clear bit and byte counters, set busy, go to SHIFT; with enable=0, go to IGNORE.
REQ-016 SHIFT: each PS2_CLOCK falling edge SHALL drive DATA with the next TX bit; each rising edge SHALL shift COMMAND into RX and increment the bit counter.
REQ-017 Response bytes SHALL be 0xFF, 0x41, 0x5A, snapshot[7:0], snapshot[15:8] for bytes 0-4.
REQ-018 On the 8th rising edge SHALL drive DATA high; if RX byte 0 != 0x01 or RX byte 1 != 0x42, go to IGNORE; else if byte index < 4, go to ACK_WAIT; else increment frame_count (wrap 0xFFFF->0) and go to IGNORE.
REQ-019 ACK_WAIT SHALL count ACK_DELAY cycles, then ACK_PULSE SHALL drive ACK low for exactly ACK_WIDTH cycles, load the next TX byte, and return to SHIFT.
REQ-020 IGNORE SHALL hold DATA=1, ACK=1 until ATTENTION rises, then go to IDLE.
REQ-021 ATTENTION rising in any state SHALL abort to IDLE within 4 cycles: DATA=1, ACK=1, busy=0, frame_count unchanged unless byte 4 completed.
REQ-022 PS2_CLOCK edges arriving during ACK_WAIT/ACK_PULSE SHALL be ignored.
REQ-023 An APB write to BUTTONS mid-frame SHALL not alter the current frame; it applies from the next frame.
REQ-024 An APB write in the same cycle as the snapshot SHALL make the old value snapshotted.

Reset
REQ-025 On PRESERN low, SHALL go to IDLE, DATA=1, ACK=1, PRDATA=0, BUTTONS=0xFFFF, enable=0, frame_count=0, busy=0, synchronisers to 1.
REQ-026 Reset release mid-frame with ATTENTION low SHALL not start a frame until a fresh ATTENTION falling edge.

Structure
REQ-027 Register offsets, state encoding, and the constants 0x01, 0x42, 0x41, 0x5A SHALL live in a shared package ps2_pkg.
REQ-028 The synchroniser and edge detector SHALL be one sub-module ps2_sync_edge, instantiated three times.

Verification
REQ-029 BUTTONS=0xFFFE, enable=1, host sends 01 42 00 00 00 -> DATA bytes FF 41 5A FE FF, 4 ACK pulses of 100 cycles, frame_count=1.
REQ-030 Host byte 0 = 0x81 -> DATA FF in byte 0, then high; no ACK; frame_count unchanged.
REQ-031 ATTENTION rises after byte 2 -> DATA=1, ACK=1 within 4 cycles; busy=0; frame_count unchanged; next frame is normal.
REQ-032 BUTTONS written 0x1234 during byte 3 of a frame -> that frame returns snapshot; next frame returns 34 12.
REQ-033 enable=0 -> full host frame produces DATA constant 1, no ACK, STATUS=0.
REQ-034 frame_count preset via 65535 frames (or forced) -> next frame wraps to 0; PRESERN pulse mid-byte -> all REQ-025 values.
